// File: rtl/axi4_lite_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite register-access arbiter.
// Response codes follow the AXI4-Lite BRESP/RRESP encoding.
package axi4_lite_arb_pkg;

    localparam int REQ_N = 2;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_AW_W,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R,
        ST_RESP
    } arb_state_e;

    function automatic logic [REQ_N-1:0] id_to_onehot(input logic id);
        logic [REQ_N-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/axi4_lite_cnt_led_arbiter_rr.sv
// Combinational two-way round-robin pick; the caller owns the last_grant register.
// A lone requester always wins; on contention the one not served last wins.
module rr_arbiter_2
    import axi4_lite_arb_pkg::*;
(
    input  logic [REQ_N-1:0] req_valid,
    input  logic             last_grant,
    output logic             gnt_any,
    output logic             gnt_id
);

    always_comb begin
        gnt_any = |req_valid;
        gnt_id  = 1'b0;
        if (&req_valid) begin
            gnt_id = ~last_grant;
        end else if (req_valid[1]) begin
            gnt_id = 1'b1;
        end
    end

endmodule

// File: rtl/axi4_lite_cnt_led_arbiter.sv
// Round-robin AXI4-Lite master sharing one register slave between two requesters.
// One transaction in flight at a time; the response returns to the granted requester.
module axi4_lite_cnt_led_arbiter
    import axi4_lite_arb_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                      aclk,
    input  logic                      areset,

    input  logic [REQ_N-1:0]          req_valid,
    output logic [REQ_N-1:0]          req_ready,
    input  logic [REQ_N-1:0]          req_write,
    input  logic [REQ_N*ADDR_W-1:0]   req_addr,
    input  logic [REQ_N*DATA_W-1:0]   req_wdata,
    input  logic [REQ_N*DATA_W/8-1:0] req_wstrb,
    output logic [REQ_N-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      busy,
    output logic                      grant_id,

    output logic [ADDR_W-1:0]         m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_W-1:0]         m_axi_wdata,
    output logic [DATA_W/8-1:0]       m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_W-1:0]         m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_W-1:0]         m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    // Per-requester views of the packed command buses
    logic [ADDR_W-1:0]   req_addr_a  [REQ_N];
    logic [DATA_W-1:0]   req_wdata_a [REQ_N];
    logic [DATA_W/8-1:0] req_wstrb_a [REQ_N];

    for (genvar gi = 0; gi < REQ_N; gi++) begin : g_req_slice
        assign req_addr_a[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign req_wdata_a[gi] = req_wdata[gi*DATA_W +: DATA_W];
        assign req_wstrb_a[gi] = req_wstrb[gi*(DATA_W/8) +: DATA_W/8];
    end

    arb_state_e          state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                arvalid_q, arvalid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;

    logic gnt_any;
    logic gnt_id;
    logic grant_now;
    logic aw_done;
    logic w_done;

    rr_arbiter_2 u_rr (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .gnt_any    (gnt_any),
        .gnt_id     (gnt_id)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        arvalid_d    = arvalid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_resp_d   = rsp_resp_q;
        req_ready    = '0;
        grant_now    = 1'b0;
        aw_done      = !awvalid_q || m_axi_awready;
        w_done       = !wvalid_q || m_axi_wready;

        unique case (state_q)
            ST_IDLE: begin
                // Gating with reset keeps a command from being accepted and then discarded
                if (gnt_any && !areset) begin
                    grant_now    = 1'b1;
                    req_ready    = id_to_onehot(gnt_id);
                    grant_d      = gnt_id;
                    last_grant_d = gnt_id;
                    addr_d       = req_addr_a[gnt_id];
                    wdata_d      = req_wdata_a[gnt_id];
                    wstrb_d      = req_wstrb_a[gnt_id];
                    if (req_write[gnt_id]) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_AW_W;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_AR;
                    end
                end
            end
            ST_WR_AW_W: begin
                // AW and W retire independently, in either order
                if (m_axi_awready) awvalid_d = 1'b0;
                if (m_axi_wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) state_d = ST_WR_B;
            end
            ST_WR_B: begin
                if (m_axi_bvalid) begin
                    rsp_resp_d  = m_axi_bresp;
                    rsp_rdata_d = '0;
                    state_d     = ST_RESP;
                end
            end
            ST_RD_AR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_R;
                end
            end
            ST_RD_R: begin
                if (m_axi_rvalid) begin
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_resp_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_resp_q   <= rsp_resp_d;
        end
    end

    assign busy      = (state_q != ST_IDLE) || grant_now;
    assign grant_id  = grant_now ? gnt_id : grant_q;
    assign rsp_valid = (state_q == ST_RESP) ? id_to_onehot(grant_q) : '0;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

    assign m_axi_awaddr  = addr_q & WORD_MASK;
    assign m_axi_awprot  = PROT_DEFAULT;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == ST_WR_B);
    assign m_axi_araddr  = addr_q & WORD_MASK;
    assign m_axi_arprot  = PROT_DEFAULT;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = (state_q == ST_RD_R);

endmodule

// File: doc/axi4_lite_cnt_led_arbiter.md
Name: axi4_lite_cnt_led_arbiter

Overview:
Two-requester, round-robin AXI4-Lite master that shares one AXI4-Lite slave (the CNT_LED register block: four 32-bit registers at offsets 0x0/0x4/0x8/0xC) between two register-access requesters, e.g. a local sequencing FSM and a debug/bridge path. It accepts simple single-word read/write commands, issues exactly one AXI4-Lite transaction at a time and returns the response to the originating requester.

Parameters:
ADDR_W, 4, byte-address width on requester and AXI ports
DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
aclk  in  1  clock; AXI and requester side both sample on rising edge
areset  in  1  synchronous, active-high reset
req_valid  in  2  per-requester command valid (bit i = requester i)
req_ready  out  2  one-hot, one-cycle pulse; command accepted when valid&ready
req_write  in  2  1 = write, 0 = read
req_addr  in  2*ADDR_W  byte addresses, requester i in slice i
req_wdata  in  2*32  write data
req_wstrb  in  2*4  write byte strobes
rsp_valid  out  2  one-hot, one-cycle response pulse, no backpressure
rsp_rdata  out  32  read data, valid with rsp_valid; 0 for writes
rsp_resp  out  2  BRESP/RRESP of the completed transaction
busy  out  1  high from acceptance cycle through response cycle
grant_id  out  1  requester owning the current transaction
m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR_W/3/1/1  write address channel
m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  write data channel
m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel
m_axi_araddr/arprot/arvalid/arready  out/out/out/in  ADDR_W/3/1/1  read address channel
m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  read data channel

Behaviour:
- Reset: state IDLE, last_grant = 1 (requester 0 wins first), all AXI valids/readies, req_ready, rsp_valid, busy = 0; grant_id = 0; rsp_rdata/rsp_resp = 0.
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP.
- IDLE: if any req_valid, grant one requester. Round-robin: when both are valid, grant the one not equal to last_grant; a single valid requester wins. In the grant cycle: req_ready[g]=1; latch addr/wdata/wstrb/write; grant_id=g; last_grant=g. Next state: WR_AW_W or RD_AR.
- Address: the low 2 bits are forced to 0 on awaddr/araddr (word aligned). awprot/arprot = 3'b000.
- WR_AW_W: awvalid and wvalid assert together in the first cycle of the state. Each valid drops independently after its own handshake. Move to WR_B once both have handshaken, in either order or in the same cycle.
- WR_B: bready=1; on bvalid capture bresp, rdata = 0, then go to RESP.
- RD_AR: arvalid=1 until arready, then RD_R.
- RD_R: rready=1; on rvalid capture rdata and rresp, then go to RESP.
- RESP: rsp_valid[grant_id]=1 for exactly one cycle, then IDLE. The next grant is possible in the cycle after RESP.
- Minimum latency, with a zero-wait slave: accept T, AW/W valid T+1, B handshake T+2, rsp_valid T+3. Reads follow the same timing.
- AXI valids stay stable until handshake and never depend combinationally on ready. The block never issues a second transaction before the first completes.
- Requesters not granted see req_ready=0. They must hold req_valid and their command stable until accepted.
- Error responses (SLVERR/DECERR) pass through unchanged; no retry.
- Reset mid-transaction: all outputs return to reset values on the next edge. The slave shares areset, so no dangling transaction is tracked.
- No timeout. A stalled slave holds the FSM indefinitely.

Decomposition:
- Package axi4_lite_arb_pkg: state enum; resp constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11; REQ_N=2; PROT_DEFAULT=3'b000.
- Sub-module rr_arbiter_2: combinational pick from req_valid and last_grant. The last_grant register stays in the top level.

Test Plan:
- Requester 0 writes 0x00000001 to addr 0x0, zero-wait slave -> AW/W valid at T+1, rsp_valid=2'b01 at T+3, rsp_resp=OKAY; a readback of 0x0 returns 0x00000001 on requester 0.
- Both requesters valid from reset: req0 writes addr 0x4, req1 reads addr 0x4 -> req0 granted first, then req1, which reads the just-written value; the next simultaneous request grants req0 again (alternation).
- Slave delays awready by 3 cycles while wready is immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, a single B handshake, exactly one rsp_valid pulse.
- Requester 1 uses addr 0x7 -> araddr driven as 0x4.
- Slave returns rresp=SLVERR with rdata 0xDEADBEEF -> rsp_resp=2'b10, rsp_rdata=0xDEADBEEF.
- areset asserted while in WR_B -> next edge: all valids/readies 0, busy=0, IDLE; requester 0 wins the next grant.
